// File: rtl/id_ex_pipeline_register.sv
// rtl/id_ex_pipeline_register.sv - ID/EX stage register with load-use stall, bubble insertion and flush
// Optional macro ID_EX_ZERO_EXT_EN adds id_zero_ext to zero-extend ANDI/ORI/XORI immediates.
module id_ex_pipeline_register #(
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc4,
  input  logic [31:0]       id_rd1,
  input  logic [31:0]       id_rd2,
  input  logic [31:0]       id_imm_ext,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [CTRL_W-1:0] id_ctrl,
`ifdef ID_EX_ZERO_EXT_EN
  input  logic              id_zero_ext,
`endif
  output logic              stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc4,
  output logic [31:0]       ex_rd1,
  output logic [31:0]       ex_rd2,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_write_reg,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int MEM_READ = 1;
  localparam int REG_DST  = 5;

  logic        hz;
  logic [31:0] imm_sel;
  logic [4:0]  write_reg_sel;

  // Load in EX whose rt is read by the ID instruction; r0 never creates a dependency.
  always_comb begin
    hz = id_valid && ex_valid && ex_ctrl[MEM_READ] && (ex_rt != 5'd0) &&
         ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
  end

  assign stall = hz & ~flush;

  always_comb begin
    imm_sel = id_imm_ext;
`ifdef ID_EX_ZERO_EXT_EN
    if (id_zero_ext) begin
      imm_sel = {16'h0000, id_imm_ext[15:0]};
    end
`endif
    write_reg_sel = id_ctrl[REG_DST] ? id_rd : id_rt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc4       <= '0;
      ex_rd1       <= '0;
      ex_rd2       <= '0;
      ex_imm       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_write_reg <= '0;
      ex_ctrl      <= '0;
    end else if (flush || stall) begin
      ex_valid     <= 1'b0;
      ex_pc4       <= '0;
      ex_rd1       <= '0;
      ex_rd2       <= '0;
      ex_imm       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_write_reg <= '0;
      ex_ctrl      <= '0;
    end else begin
      ex_valid     <= id_valid;
      ex_pc4       <= id_pc4;
      ex_rd1       <= id_rd1;
      ex_rd2       <= id_rd2;
      ex_imm       <= imm_sel;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_write_reg <= write_reg_sel;
      ex_ctrl      <= id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// tb/tb_id_ex_pipeline_register.sv - scoreboard bench for id_ex_pipeline_register
// Honours ID_EX_ZERO_EXT_EN when defined; uses CNT_W=4 so counter saturation is reachable.
`timescale 1ns/1ps
module tb_id_ex_pipeline_register;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, id_valid, id_uses_rs, id_uses_rt, id_zero_ext;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm_ext;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [8:0]  id_ctrl;
  logic        stall, ex_valid;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_write_reg;
  logic [8:0]  ex_ctrl;
  logic [CW-1:0] stall_count;

  typedef struct packed {
    logic flush, valid;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0] rs, rt, rd;
    logic uses_rs, uses_rt;
    logic [8:0] ctrl;
    logic zext;
  } in_t;

  typedef struct packed {
    logic valid;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0] rs, rt, wr;
    logic [8:0] ctrl;
    logic [CW-1:0] cnt;
  } ex_t;

  id_ex_pipeline_register #(.CTRL_W(9), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm_ext(id_imm_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl),
`ifdef ID_EX_ZERO_EXT_EN
    .id_zero_ext(id_zero_ext),
`endif
    .stall(stall), .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_write_reg(ex_write_reg), .ex_ctrl(ex_ctrl), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  ex_t  ex_q[$];
  logic stall_q[$];
  ex_t  m;
  logic last_stall;

  localparam logic [8:0] LW  = 9'h01B;
  localparam logic [8:0] ADD = 9'h0A1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor for registered EX state, one entry per clock edge.
  initial forever begin
    ex_t a, e;
    @(posedge clk); #1;
    if (ex_q.size() > 0) begin
      e = ex_q.pop_front();
      a = {ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_write_reg, ex_ctrl, stall_count};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL ex_state got=%h exp=%h", a, e);
      end
    end
  end

  // Monitor for the combinational stall, sampled mid-cycle.
  initial forever begin
    logic e;
    @(negedge clk);
    if (stall_q.size() > 0) begin
      e = stall_q.pop_front();
      checks++;
      if (stall !== e) begin
        failures++;
        $display("FAIL stall got=%b exp=%b", stall, e);
      end
    end
  end

  task automatic apply(input in_t i);
    flush = i.flush; id_valid = i.valid; id_pc4 = i.pc4; id_rd1 = i.rd1; id_rd2 = i.rd2;
    id_imm_ext = i.imm; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    id_uses_rs = i.uses_rs; id_uses_rt = i.uses_rt; id_ctrl = i.ctrl; id_zero_ext = i.zext;
  endtask

  function automatic logic model_stall(input in_t i);
    logic dep;
    dep = (i.uses_rs && i.rs == m.rt) || (i.uses_rt && i.rt == m.rt);
    return i.valid && m.valid && m.ctrl[1] && m.rt != 0 && dep && !i.flush;
  endfunction

  task automatic issue(input in_t i);
    ex_t nm;
    logic s;
    @(posedge clk); #2;
    apply(i);
    s = model_stall(i);
    stall_q.push_back(s);
    nm = '0;
    if (!i.flush && !s) begin
      nm.valid = i.valid;
      nm.pc4 = i.pc4; nm.rd1 = i.rd1; nm.rd2 = i.rd2; nm.imm = i.imm;
`ifdef ID_EX_ZERO_EXT_EN
      if (i.zext) nm.imm = {16'h0000, i.imm[15:0]};
`endif
      nm.rs = i.rs; nm.rt = i.rt;
      nm.wr = i.ctrl[5] ? i.rd : i.rt;
      nm.ctrl = i.valid ? i.ctrl : 9'h0;
    end
    nm.cnt = (s && m.cnt != {CW{1'b1}}) ? m.cnt + 1'b1 : m.cnt;
    m = nm;
    ex_q.push_back(m);
    last_stall = s;
  endtask

  function automatic in_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic urs, input logic urt,
                             input logic [8:0] ctrl);
    in_t i;
    i.flush = 1'b0; i.valid = v; i.pc4 = $urandom; i.rd1 = $urandom; i.rd2 = $urandom;
    i.imm = $urandom; i.rs = rs; i.rt = rt; i.rd = rd; i.uses_rs = urs; i.uses_rt = urt;
    i.ctrl = ctrl; i.zext = 1'b0;
    return i;
  endfunction

  initial begin
    in_t i, held;
    last_stall = 1'b0;
    m = '0;
    rst_n = 1'b0;
    i = mk(1'b1, 5'd7, 5'd8, 5'd9, 1'b1, 1'b1, 9'h1FF);
    i.pc4 = 32'hFFFF_FFFF; i.imm = 32'h1234_5678;
    apply(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_data", 64'(ex_pc4 | ex_rd1 | ex_rd2 | ex_imm), 64'd0);
    chk("rst_ex_regs", 64'({ex_rs, ex_rt, ex_write_reg}), 64'd0);
    chk("rst_ex_ctrl", 64'(ex_ctrl), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_stall_count", 64'(stall_count), 64'd0);
    rst_n = 1'b1;

    i = mk(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 9'h011);
    i.imm = 32'hFFFF_8000;
    issue(i);
    issue(mk(1'b1, 5'd1, 5'd5, 5'd9, 1'b1, 1'b1, 9'h021));
    issue(mk(1'b1, 5'd1, 5'd5, 5'd9, 1'b1, 1'b1, 9'h001));

    issue(mk(1'b1, 5'd4, 5'd8, 5'd0, 1'b1, 1'b0, LW));
    held = mk(1'b1, 5'd8, 5'd3, 5'd10, 1'b1, 1'b1, ADD);
    issue(held);
    issue(held);

    issue(mk(1'b1, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, LW));
    issue(mk(1'b1, 5'd0, 5'd3, 5'd10, 1'b1, 1'b1, ADD));
    issue(mk(1'b1, 5'd4, 5'd8, 5'd0, 1'b1, 1'b0, LW));
    issue(mk(1'b1, 5'd1, 5'd8, 5'd10, 1'b0, 1'b0, ADD));

    issue(mk(1'b1, 5'd4, 5'd8, 5'd0, 1'b1, 1'b0, LW));
    i = mk(1'b1, 5'd8, 5'd3, 5'd10, 1'b1, 1'b1, ADD);
    i.flush = 1'b1;
    issue(i);

`ifdef ID_EX_ZERO_EXT_EN
    i = mk(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 9'h011);
    i.imm = 32'hFFFF_8001; i.zext = 1'b1;
    issue(i);
    i.zext = 1'b0;
    issue(i);
`endif

    // Repeated load-use pairs drive the 4-bit counter into saturation.
    for (int k = 0; k < 17; k++) begin
      issue(mk(1'b1, 5'd4, 5'd6, 5'd0, 1'b1, 1'b0, LW));
      held = mk(1'b1, 5'd2, 5'd6, 5'd11, 1'b1, 1'b1, ADD);
      issue(held);
      issue(held);
    end

    last_stall = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!last_stall) begin
        held.flush = 1'b0; held.valid = ($urandom_range(0, 7) != 0);
        held.pc4 = $urandom; held.rd1 = $urandom; held.rd2 = $urandom; held.imm = $urandom;
        held.rs = 5'($urandom_range(0, 3)); held.rt = 5'($urandom_range(0, 3));
        held.rd = 5'($urandom_range(0, 31));
        held.uses_rs = 1'($urandom); held.uses_rt = 1'($urandom);
        held.ctrl = 9'($urandom); held.zext = 1'($urandom);
      end
      i = held;
      i.flush = ($urandom_range(0, 9) == 0);
      issue(i);
    end

    issue(mk(1'b1, 5'd4, 5'd8, 5'd0, 1'b1, 1'b0, LW));
    @(posedge clk); #2;
    i = mk(1'b1, 5'd8, 5'd3, 5'd10, 1'b1, 1'b1, ADD);
    apply(i);
    stall_q.push_back(model_stall(i));
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midstall_rst_valid", 64'(ex_valid), 64'd0);
    chk("midstall_rst_ctrl", 64'(ex_ctrl), 64'd0);
    chk("midstall_rst_stall", 64'(stall), 64'd0);
    chk("midstall_rst_count", 64'(stall_count), 64'd0);

    for (int n = 0; n < 10 && (ex_q.size() > 0 || stall_q.size() > 0); n++) @(posedge clk);
    chk("scoreboard_drained", 64'(ex_q.size() + stall_q.size()), 64'd0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_register.md
# id_ex_pipeline_register

ID/EX pipeline stage of the five-stage MIPS pipeline. It sits directly downstream of the decode-stage sign extender and register file. On each clock it captures the decoded instruction into the execute stage: the 32-bit sign-extended immediate, register operands and control bundle. It also owns load-use hazard detection: it raises a stall and inserts a bubble, and it accepts branch flushes.

## Interface
Parameters:
- `CTRL_W`, 9: control bundle width. Bit map: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] alu_src, [5] reg_dst, [8:6] alu_op.
- `CNT_W`, 16: width of the stall performance counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: branch/jump taken; squash the ID instruction.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_pc4` in 32: PC+4 of the ID instruction.
- `id_rd1`, `id_rd2` in 32 each: register file read data.
- `id_imm_ext` in 32: sign-extended immediate from the sign extender.
- `id_rs`, `id_rt`, `id_rd` in 5 each: register specifiers.
- `id_uses_rs`, `id_uses_rt` in 1 each: the instruction actually reads rs / rt.
- `id_ctrl` in CTRL_W: decoded control bundle.
- `stall` out 1: combinational; holds the PC and IF/ID.
- `ex_valid` out 1: the EX stage holds a real instruction.
- `ex_pc4`, `ex_rd1`, `ex_rd2`, `ex_imm` out 32 each.
- `ex_rs`, `ex_rt` out 5 each.
- `ex_write_reg` out 5: resolved destination register.
- `ex_ctrl` out CTRL_W.
- `stall_count` out CNT_W: saturating count of stall cycles.

## Operation
- The hazard condition is `hz`. All of the following must hold:
  - `id_valid` is set.
  - `ex_valid` is set.
  - `ex_ctrl[1]` (mem_read) is set.
  - `ex_rt` is not 0.
  - `id_uses_rs` is set and `id_rs == ex_rt`, or `id_uses_rt` is set and `id_rt == ex_rt`.
- `stall = hz & ~flush`. A flush overrides a stall because the stalled instruction is being discarded anyway.
- On each rising edge the next state is chosen in this priority order:
  1. `flush`: load a bubble.
  2. `stall`: load a bubble.
  3. Otherwise: capture the ID inputs.
- A bubble sets `ex_valid=0` and `ex_ctrl=0`. The data fields (`ex_pc4`, `ex_rd1`, `ex_rd2`, `ex_imm`, `ex_rs`, `ex_rt`, `ex_write_reg`) are also set to 0, so the bench can compare them deterministically.
- A capture sets:
  - `ex_valid = id_valid`.
  - `ex_ctrl = id_valid ? id_ctrl : 0`.
  - All data fields are copied unchanged.
  - `ex_write_reg = id_ctrl[5] ? id_rd : id_rt`.
- `ex_imm` passes the 32-bit input through unchanged. It is never re-extended here, except when the configuration macro enables zero-extension.
- `stall_count` increments on every edge where `stall=1` and saturates at 2^CNT_W−1.

## Timing
- Latency: 1 cycle. ID values presented before edge N appear on the `ex_*` outputs after edge N.
- `stall` is purely combinational from `id_*` and the registered `ex_*` state. There is no internal `id_*` → `stall` → `id_*` loop.
- A stall lasts exactly 1 cycle per load-use pair. After the bubble, `ex_valid=0`, so `hz` drops and the held instruction is captured on the next edge.
- Reset is asserted asynchronously and released synchronously (external synchronizer). While `rst_n=0`, every output is 0, including `stall_count`, and `stall=0`.
- A reset asserted in the middle of a stall discards the pending instruction. Recovery is handled upstream by the PC reset.
- Simultaneous `flush` and `hz`: bubble, `stall=0`, counter not incremented.

## Configuration
- Macro: `ID_EX_ZERO_EXT_EN`.
- When defined:
  - Adds input port `id_zero_ext` (1 bit).
  - On capture with `id_zero_ext=1`: `ex_imm = {16'h0000, id_imm_ext[15:0]}`. This serves ANDI/ORI/XORI.
  - With `id_zero_ext=0`, `ex_imm` is the unchanged input.
- When undefined: the port is absent and `ex_imm` is always the unchanged input.

## Test plan
- Reset: hold `rst_n=0` with all inputs driven nonzero → every `ex_*` output 0, `stall=0`, `stall_count=0`. Release reset, apply `id_imm_ext=32'hFFFF8000` with `id_valid=1` → after one edge `ex_imm=32'hFFFF8000`, `ex_valid=1`.
- Destination mux: `id_rt=5`, `id_rd=9`. `id_ctrl[5]=1` → `ex_write_reg=9`. `id_ctrl[5]=0` → `ex_write_reg=5`.
- Load-use: LW with rt=8 in EX, followed by an ADD in ID with rs=8 and `id_uses_rs=1`.
  - Cycle with the ADD in ID: `stall=1`.
  - Next edge: bubble (`ex_valid=0`, `ex_ctrl=0`), `stall_count=1`.
  - Following edge: the ADD is captured and `stall=0`.
- No false stall:
  - LW rt=0 in EX, ID rs=0 → `stall=0`.
  - LW rt=8 in EX, ID rt=8 with `id_uses_rt=0` → `stall=0`.
- Flush priority: load-use condition present and `flush=1` → `stall=0`, bubble captured, `stall_count` unchanged.
- Config with `ID_EX_ZERO_EXT_EN`: `id_imm_ext=32'hFFFF8001`. `id_zero_ext=1` → `ex_imm=32'h00008001`. `id_zero_ext=0` → `ex_imm=32'hFFFF8001`.
